alu_arbiter: RTL and testbench

Shares the single multi-cycle-processor ALU between two requesters (requester 0: execute path; requester 1: PC/address-update path). It accepts one operation at a time over a valid/ready handshake and registers the operands so ALU inputs stay stable for a programmable settle time. It captures `op_0` and `change_pc` and returns them on a per-requester response handshake. Grants alternate round-robin when both requesters are pending.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_arbiter_rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_pkg;

    localparam int OPW = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    typedef logic req_idx_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester
// that did not win last time.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_idx_t   i_last_grant,
    output logic [1:0] o_grant
);

    assign o_grant[0] = i_valid[0] &
                        (~i_valid[1] | i_last_grant);
    assign o_grant[1] = i_valid[1] &
                        (~i_valid[0] | ~i_last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute path (r0) and the
// PC-update path (r1); operands held for EXEC_CYCLES.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int OPW         = alu_pkg::OPW,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [OPW-1:0]   r0_op,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [OPW-1:0]   r1_op,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_change_pc,
    output logic [WIDTH-1:0] alu_ip_0,
    output logic [WIDTH-1:0] alu_ip_1,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_op_0,
    input  logic             alu_change_pc
);

    import alu_pkg::*;

    localparam logic [3:0] CNT_LOAD =
        4'(EXEC_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_next;
    req_idx_t         r_last;
    req_idx_t         r_owner;
    req_idx_t         w_win;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_ip0;
    logic [WIDTH-1:0] r_ip1;
    logic [WIDTH-1:0] r_res;
    logic [OPW-1:0]   r_opc;
    logic             r_cpc;
    logic [1:0]       w_gnt;
    logic             w_accept;
    logic             w_done;

    rr_arb2 u_arb (
        .i_valid      ({r1_valid, r0_valid}),
        .i_last_grant (r_last),
        .o_grant      (w_gnt)
    );

    assign w_accept = (r_state == IDLE) & (|w_gnt);
    assign w_win    = w_gnt[1];
    assign w_done   = r_owner ? r1_rsp_ready
                              : r0_rsp_ready;

    always_comb begin
        w_next       = r_state;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                r0_ready = w_gnt[0];
                r1_ready = w_gnt[1];
                if (w_accept) w_next = EXEC;
            end
            EXEC: begin
                if (r_cnt == 4'd0) w_next = RESP;
            end
            RESP: begin
                r0_rsp_valid = ~r_owner;
                r1_rsp_valid = r_owner;
                if (w_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_cnt   <= 4'd0;
            r_ip0   <= '0;
            r_ip1   <= '0;
            r_opc   <= '0;
            r_res   <= '0;
            r_cpc   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ip0   <= w_win ? r1_a : r0_a;
                r_ip1   <= w_win ? r1_b : r0_b;
                r_opc   <= w_win ? r1_op : r0_op;
                r_owner <= w_win;
                r_last  <= w_win;
                r_cnt   <= CNT_LOAD;
            end
            if (r_state == EXEC) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_res <= alu_op_0;
                    r_cpc <= alu_change_pc;
                end
            end
        end
    end

    assign alu_ip_0      = r_ip0;
    assign alu_ip_1      = r_ip1;
    assign alu_opcode    = r_opc;
    assign rsp_result    = r_res;
    assign rsp_change_pc = r_cpc;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: two arbiters (EXEC_CYCLES 1 and 4)
// with a stub adder ALU, a timing-level model and directed cases.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;

    logic        r0rdy [2];
    logic        r1rdy [2];
    logic        rv0   [2];
    logic        rv1   [2];
    logic [31:0] res   [2];
    logic        cpc   [2];
    logic [31:0] ip0   [2];
    logic [31:0] ip1   [2];
    logic [2:0]  opc   [2];
    logic [31:0] aop   [2];
    logic        acpc  [2];

    int npass = 0;
    int ntot  = 0;
    bit mon_en = 0;

    function automatic int ecyc(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        assign aop[k]  = ip0[k] + ip1[k];
        assign acpc[k] = (ip0[k] == ip1[k]);
        alu_arbiter #(
            .WIDTH(32), .OPW(3),
            .EXEC_CYCLES((k == 0) ? 1 : 4)
        ) dut (
            .clk(clk), .reset(reset),
            .r0_valid(v0), .r0_ready(r0rdy[k]),
            .r0_a(a0), .r0_b(b0), .r0_op(op0),
            .r0_rsp_valid(rv0[k]), .r0_rsp_ready(rr0),
            .r1_valid(v1), .r1_ready(r1rdy[k]),
            .r1_a(a1), .r1_b(b1), .r1_op(op1),
            .r1_rsp_valid(rv1[k]), .r1_rsp_ready(rr1),
            .rsp_result(res[k]),
            .rsp_change_pc(cpc[k]),
            .alu_ip_0(ip0[k]), .alu_ip_1(ip1[k]),
            .alu_opcode(opc[k]),
            .alu_op_0(aop[k]),
            .alu_change_pc(acpc[k])
        );
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s u%0d got %h want %h",
                      nm, k, act, exp);
    endtask

    // Model: per instance, busy with an op for E+1 cycles
    // after accept, then responding until rsp_ready.
    bit          m_busy [2];
    bit          m_own  [2];
    bit          m_last [2];
    int          m_t    [2];
    logic [31:0] m_ip0  [2];
    logic [31:0] m_ip1  [2];
    logic [2:0]  m_opc  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_res  [2];
    bit          m_pcp  [2];
    bit          m_cpc  [2];

    always @(negedge clk) begin
        int  w;
        bit  rsp;
        bit  take;
        for (int k = 0; k < 2; k++) begin
            w = -1;
            if (!m_busy[k]) begin
                if (v0 && v1) w = m_last[k] ? 0 : 1;
                else if (v0) w = 0;
                else if (v1) w = 1;
            end
            rsp  = m_busy[k] && (m_t[k] > ecyc(k));
            take = m_own[k] ? rr1 : rr0;
            if (mon_en) begin
                chk("rdy0", k, r0rdy[k], w == 0);
                chk("rdy1", k, r1rdy[k], w == 1);
                chk("rv0", k, rv0[k], rsp && !m_own[k]);
                chk("rv1", k, rv1[k], rsp && m_own[k]);
                chk("res", k, res[k], m_res[k]);
                chk("cpc", k, cpc[k], m_cpc[k]);
                chk("ip0", k, ip0[k], m_ip0[k]);
                chk("ip1", k, ip1[k], m_ip1[k]);
                chk("opc", k, opc[k], m_opc[k]);
            end
            if (reset) begin
                m_busy[k] = 0; m_own[k] = 0;
                m_last[k] = 1; m_t[k] = 0;
                m_ip0[k] = 0; m_ip1[k] = 0;
                m_opc[k] = 0; m_res[k] = 0;
                m_cpc[k] = 0;
            end else if (w >= 0) begin
                m_busy[k] = 1;
                m_own[k]  = (w == 1);
                m_last[k] = (w == 1);
                m_t[k]    = 1;
                m_ip0[k]  = (w == 1) ? a1 : a0;
                m_ip1[k]  = (w == 1) ? b1 : b0;
                m_opc[k]  = (w == 1) ? op1 : op0;
                m_pend[k] = m_ip0[k] + m_ip1[k];
                m_pcp[k]  = (m_ip0[k] == m_ip1[k]);
            end else if (m_busy[k]) begin
                if (rsp) begin
                    if (take) m_busy[k] = 0;
                end else begin
                    m_t[k]++;
                    if (m_t[k] > ecyc(k)) begin
                        m_res[k] = m_pend[k];
                        m_cpc[k] = m_pcp[k];
                    end
                end
            end
        end
    end

    task automatic drv();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        repeat (n) drv();
    endtask

    task automatic do_reset();
        drv(); reset = 1;
        drv(); reset = 0;
    endtask

    int          acc_cyc [$];
    int          acc_who [$];
    logic [31:0] rs      [$];
    bit          got;

    initial begin
        reset = 1; v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
        drv(); drv(); reset = 0;
        mon_en = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_res", k, res[k], 0);
            chk("rst_ip0", k, ip0[k], 0);
            chk("rst_opc", k, opc[k], 0);
            chk("rst_rv0", k, rv0[k], 0);
        end

        drv(); v0 = 1; a0 = 10; b0 = 619; op0 = 4;
        @(negedge clk); chk("s_rdy", 0, r0rdy[0], 1);
        drv(); v0 = 0;
        @(negedge clk);
        chk("s_opc", 0, opc[0], 4);
        chk("s_opc", 1, opc[1], 4);
        chk("s_rv_early", 0, rv0[0], 0);
        @(negedge clk);
        chk("s_rv0", 0, rv0[0], 1);
        chk("s_res", 0, res[0], 629);
        chk("s_cpc", 0, cpc[0], 0);
        chk("s_rv1", 0, rv1[0], 0);
        idle(8);

        do_reset();
        v0 = 1; a0 = 55; b0 = 3; op0 = 5;
        v1 = 1; a1 = 9; b1 = 20; op1 = 6;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (r0rdy[0]) begin
                acc_cyc.push_back(c); acc_who.push_back(0);
            end
            if (r1rdy[0]) begin
                acc_cyc.push_back(c); acc_who.push_back(1);
            end
            if (rv0[0] || rv1[0]) rs.push_back(res[0]);
        end
        chk("tie_n", 0, acc_who.size() >= 3, 1);
        chk("tie_rn", 0, rs.size() >= 3, 1);
        if (acc_who.size() >= 3) begin
            chk("tie_w0", 0, acc_who[0], 0);
            chk("tie_w1", 0, acc_who[1], 1);
            chk("tie_w2", 0, acc_who[2], 0);
            chk("tie_d1", 0, acc_cyc[1] - acc_cyc[0], 3);
            chk("tie_d2", 0, acc_cyc[2] - acc_cyc[1], 3);
        end
        if (rs.size() >= 3) begin
            chk("tie_r0", 0, rs[0], 58);
            chk("tie_r1", 0, rs[1], 29);
            chk("tie_r2", 0, rs[2], 58);
        end
        idle(10);

        do_reset();
        v1 = 1; a1 = 5; b1 = 5; op1 = 2; rr1 = 0;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (r1rdy[0]) got = 1;
            else drv();
        end
        chk("bp_acc", 0, got, 1);
        drv(); v1 = 0; v0 = 1; a0 = 7; b0 = 1; op0 = 1;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            chk("bp_rdy0", 0, r0rdy[0], 0);
            if (rv1[0]) got = 1;
        end
        chk("bp_rsp", 0, got, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_v", 0, rv1[0], 1);
            chk("bp_res", 0, res[0], 10);
            chk("bp_cpc", 0, cpc[0], 1);
            chk("bp_rdy0h", 0, r0rdy[0], 0);
            @(negedge clk);
        end
        drv(); rr1 = 1;
        @(negedge clk); chk("bp_last", 0, rv1[0], 1);
        @(negedge clk);
        chk("bp_rel", 0, rv1[0], 0);
        chk("bp_next", 0, r0rdy[0], 1);
        idle(10);

        do_reset();
        v0 = 1; a0 = 8; b0 = 235; op0 = 3;
        @(negedge clk); chk("e4_rdy", 1, r0rdy[1], 1);
        drv(); v0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("e4_ip0", 1, ip0[1], 8);
            chk("e4_ip1", 1, ip1[1], 235);
            chk("e4_opc", 1, opc[1], 3);
            chk("e4_norv", 1, rv0[1], 0);
        end
        @(negedge clk);
        chk("e4_rv", 1, rv0[1], 1);
        chk("e4_res", 1, res[1], 243);
        idle(10);

        do_reset();
        v0 = 1; a0 = 200; b0 = 235; op0 = 7;
        @(negedge clk); chk("rm_rdy", 0, r0rdy[0], 1);
        drv(); v0 = 0; reset = 1;
        drv(); reset = 0;
        @(negedge clk);
        chk("rm_ip0", 0, ip0[0], 0);
        chk("rm_opc", 0, opc[0], 0);
        chk("rm_res", 0, res[0], 0);
        for (int i = 0; i < 4; i++) begin
            chk("rm_norv", 0, rv0[0] | rv1[0], 0);
            @(negedge clk);
        end
        drv(); v1 = 1; a1 = 3; b1 = 4; op1 = 1;
        @(negedge clk); chk("rm_r1", 0, r1rdy[0], 1);
        drv(); v1 = 0;
        idle(6);
        v0 = 1; v1 = 1;
        @(negedge clk);
        chk("rm_tie0", 0, r0rdy[0], 1);
        chk("rm_tie1", 0, r1rdy[0], 0);
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            drv();
            v0  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            a0  = $urandom;
            a1  = $urandom;
            b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 0;
        idle(20);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
